// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M/RV64M multiply/divide unit:
// funct3 encodings, FSM states and elaboration-time parameter checks.
package muldiv_pkg;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic is_signed_a(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic bit xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic bit unroll_legal(input int xlen, input int unroll);
    return ((unroll == 1) || (unroll == 2) || (unroll == 4)) && ((xlen % unroll) == 0);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);
  import muldiv_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            kill;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, a, b, kill, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, a, b, kill, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring
// shift-subtract for divide, over a shared 2*XLEN accumulator.
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   opnd,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] rem_sh_s;
  logic [XLEN:0] trial_s;

  // Multiply: {hi,lo} with multiplier in lo; divide: {rem,quotient/dividend}
  always_comb begin
    sum_s    = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    rem_sh_s = acc_in[2*XLEN-1:XLEN-1];
    trial_s  = rem_sh_s - {1'b0, opnd};
    if (div_mode) begin
      if (!trial_s[XLEN]) begin
        acc_out = {trial_s[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
      end else begin
        acc_out = {rem_sh_s[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_out = {sum_s, acc_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative M-extension multiply/divide unit: sign-magnitude datapath,
// UNROLL chained steps per cycle, sign fixup before the result is presented.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int UNROLL       = 1,
  parameter int FAST_SPECIAL = 1
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);

  localparam int STEPS = XLEN / UNROLL;
  localparam int CNT_W = $clog2(STEPS) + 1;

  if (!xlen_legal(XLEN) || !unroll_legal(XLEN, UNROLL)) begin : g_param_check
    $error("muldiv_iter: XLEN must be 32/64 and UNROLL 1/2/4 dividing XLEN");
  end

  state_e              state_r, state_next_s;
  logic [2:0]          op_r;
  logic                div_r, neg_q_r, neg_r_r, div_zero_r;
  logic [2*XLEN-1:0]   acc_r;
  logic [XLEN-1:0]     opnd_r, result_r;
  logic [CNT_W-1:0]    cnt_r;

  logic                accept_s, a_neg_s, b_neg_s, b_zero_s, ovf_s, special_s, last_s;
  logic [XLEN-1:0]     a_mag_s, b_mag_s, special_res_s, fix_res_s, quo_s, rem_s;
  logic [2*XLEN-1:0]   prod_s;
  logic [2*XLEN-1:0]   chain_s [UNROLL+1];

  assign bus.in_ready  = (state_r == IDLE) && !bus.kill;
  assign bus.out_valid = (state_r == DONE);
  assign bus.busy      = (state_r != IDLE);
  assign bus.result    = result_r;

  assign accept_s  = bus.in_valid && bus.in_ready;
  assign a_neg_s   = is_signed_a(bus.op) && bus.a[XLEN-1];
  assign b_neg_s   = is_signed_b(bus.op) && bus.b[XLEN-1];
  assign a_mag_s   = a_neg_s ? -bus.a : bus.a;
  assign b_mag_s   = b_neg_s ? -bus.b : bus.b;
  assign b_zero_s  = (bus.b == {XLEN{1'b0}});
  assign ovf_s     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                     (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b == {XLEN{1'b1}});
  assign special_s = (FAST_SPECIAL != 0) && bus.op[2] && (b_zero_s || ovf_s);
  assign last_s    = (cnt_r == CNT_W'(STEPS - 1));

  assign chain_s[0] = acc_r;
  for (genvar i = 0; i < UNROLL; i++) begin : g_step
    muldiv_step #(.XLEN(XLEN)) u_step (
      .div_mode (div_r),
      .acc_in   (chain_s[i]),
      .opnd     (opnd_r),
      .acc_out  (chain_s[i+1])
    );
  end

  // Next-state logic; kill wins over every other input
  always_comb begin
    state_next_s = state_r;
    if (bus.kill) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) state_next_s = special_s ? DONE : CALC;
          else          state_next_s = IDLE;
        end
        CALC: begin
          if (last_s) state_next_s = FIXUP;
          else        state_next_s = CALC;
        end
        FIXUP:   state_next_s = DONE;
        DONE: begin
          if (bus.out_ready) state_next_s = IDLE;
          else               state_next_s = DONE;
        end
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Bypass results: x/0 gives all ones / a, overflow gives a / 0
  always_comb begin
    special_res_s = {XLEN{1'b0}};
    if (b_zero_s) begin
      special_res_s = bus.op[1] ? bus.a : {XLEN{1'b1}};
    end else begin
      special_res_s = bus.op[1] ? {XLEN{1'b0}} : bus.a;
    end
  end

  // Sign restore and result selection; x/0 quotient is forced to all ones
  always_comb begin
    prod_s    = neg_q_r ? -acc_r : acc_r;
    quo_s     = neg_q_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
    rem_s     = neg_r_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
    fix_res_s = {XLEN{1'b0}};
    case (op_r)
      OP_MUL:                        fix_res_s = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res_s = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:               fix_res_s = div_zero_r ? {XLEN{1'b1}} : quo_s;
      OP_REM, OP_REMU:               fix_res_s = rem_s;
      default:                       fix_res_s = {XLEN{1'b0}};
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_next_s;
  end

  // Datapath registers: latch on accept, iterate in CALC, commit in FIXUP
  always_ff @(posedge clk) begin
    if (rst) begin
      op_r       <= 3'd0;
      div_r      <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      div_zero_r <= 1'b0;
      acc_r      <= {(2*XLEN){1'b0}};
      opnd_r     <= {XLEN{1'b0}};
      result_r   <= {XLEN{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      op_r       <= bus.op;
      div_r      <= bus.op[2];
      neg_q_r    <= a_neg_s ^ b_neg_s;
      neg_r_r    <= a_neg_s;
      div_zero_r <= b_zero_s;
      cnt_r      <= {CNT_W{1'b0}};
      if (bus.op[2]) begin
        acc_r  <= {{XLEN{1'b0}}, a_mag_s};
        opnd_r <= b_mag_s;
      end else begin
        acc_r  <= {{XLEN{1'b0}}, b_mag_s};
        opnd_r <= a_mag_s;
      end
      if (special_s) result_r <= special_res_s;
    end else if ((state_r == CALC) && !bus.kill) begin
      acc_r <= chain_s[UNROLL];
      cnt_r <= cnt_r + CNT_W'(1);
    end else if ((state_r == FIXUP) && !bus.kill) begin
      result_r <= fix_res_s;
    end
  end

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: three XLEN=32 instances (UNROLL 1 / UNROLL 2 / no fast path)
// driven through a shared stimulus, with a result queue and a reference model.
module tb_muldiv_iter;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_d, kill_d, out_ready_d;
  logic [2:0]  op_d;
  logic [31:0] a_d, b_d;
  int          sel;

  logic        in_ready_o, out_valid_o, busy_o;
  logic [31:0] result_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb_q [$];

  typedef struct {
    int          s;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  muldiv_if #(.XLEN(32)) bus0 ();
  muldiv_if #(.XLEN(32)) bus1 ();
  muldiv_if #(.XLEN(32)) bus2 ();

  assign bus0.in_valid  = in_valid_d && (sel == 0);
  assign bus0.kill      = kill_d && (sel == 0);
  assign bus0.out_ready = (sel == 0) ? out_ready_d : 1'b1;
  assign bus0.op = op_d;
  assign bus0.a  = a_d;
  assign bus0.b  = b_d;
  assign bus1.in_valid  = in_valid_d && (sel == 1);
  assign bus1.kill      = kill_d && (sel == 1);
  assign bus1.out_ready = (sel == 1) ? out_ready_d : 1'b1;
  assign bus1.op = op_d;
  assign bus1.a  = a_d;
  assign bus1.b  = b_d;
  assign bus2.in_valid  = in_valid_d && (sel == 2);
  assign bus2.kill      = kill_d && (sel == 2);
  assign bus2.out_ready = (sel == 2) ? out_ready_d : 1'b1;
  assign bus2.op = op_d;
  assign bus2.a  = a_d;
  assign bus2.b  = b_d;

  muldiv_iter #(.XLEN(32), .UNROLL(1), .FAST_SPECIAL(1)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  muldiv_iter #(.XLEN(32), .UNROLL(2), .FAST_SPECIAL(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  muldiv_iter #(.XLEN(32), .UNROLL(1), .FAST_SPECIAL(0)) u_dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  always_comb begin
    case (sel)
      1: begin in_ready_o = bus1.in_ready; out_valid_o = bus1.out_valid; busy_o = bus1.busy; result_o = bus1.result; end
      2: begin in_ready_o = bus2.in_ready; out_valid_o = bus2.out_valid; busy_o = bus2.busy; result_o = bus2.result; end
      default: begin in_ready_o = bus0.in_ready; out_valid_o = bus0.out_valid; busy_o = bus0.busy; result_o = bus0.result; end
    endcase
  end

  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ub_s;
    logic [63:0] p;
    logic [31:0] r;
    sa   = {{32{a[31]}}, a};
    sb   = {{32{b[31]}}, b};
    ub_s = {32'd0, b};
    p    = 64'd0;
    r    = 32'd0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub_s; r = p[63:32]; end
      3'd3: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      3'd4: if (b == 32'd0) r = 32'hFFFF_FFFF; else begin p = sa / sb; r = p[31:0]; end
      3'd5: r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: if (b == 32'd0) r = a; else begin p = sa % sb; r = p[31:0]; end
      default: r = (b == 32'd0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one request, measure latency from accept, compare against the queue head
  task automatic run_op(input int s, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int n;
    logic rdy_seen;
    logic [31:0] want;
    sel = s;
    sb_q.push_back(exp);
    @(negedge clk); in_valid_d = 1'b1; op_d = op; a_d = a; b_d = b; #1;
    n = 0;
    while (!in_ready_o && n < 20) begin @(negedge clk); #1; n++; end
    check({name, ".accept"}, in_ready_o, 1);
    @(negedge clk); in_valid_d = 1'b0; op_d = 3'($urandom); a_d = $urandom; b_d = $urandom; #1;
    n = 1; rdy_seen = 1'b0;
    while (!out_valid_o && n < 200) begin
      if (in_ready_o) rdy_seen = 1'b1;
      @(negedge clk); #1; n++;
    end
    check({name, ".latency"}, n, lat);
    check({name, ".ready_low"}, rdy_seen, 0);
    want = sb_q.pop_front();
    check({name, ".result"}, result_o, want);
    out_ready_d = 1'b1;
    @(negedge clk); out_ready_d = 1'b0; #1;
    check({name, ".idle_after"}, busy_o, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen, stable_ok;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    logic [31:0] held;

    sel = 0; rst = 1'b1; in_valid_d = 1'b0; kill_d = 1'b0; out_ready_d = 1'b0;
    op_d = 3'd0; a_d = 32'd0; b_d = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0; #1;
    check("reset.in_ready", in_ready_o, 1);
    check("reset.out_valid", out_valid_o, 0);
    check("reset.busy", busy_o, 0);
    check("reset.result", result_o, 0);

    vecs.push_back('{0, OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34});
    vecs.push_back('{0, OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34});
    vecs.push_back('{0, OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34});
    vecs.push_back('{0, OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34});
    vecs.push_back('{0, OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34});
    vecs.push_back('{0, OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34});
    vecs.push_back('{0, OP_DIVU,   32'd100,        32'd7,         32'd14,        34});
    vecs.push_back('{0, OP_REMU,   32'd100,        32'd7,         32'd2,         34});
    vecs.push_back('{1, OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 18});
    vecs.push_back('{1, OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 18});
    vecs.push_back('{1, OP_DIVU,   32'd100,        32'd7,         32'd14,        18});
    vecs.push_back('{1, OP_REMU,   32'd100,        32'd7,         32'd2,         18});
    vecs.push_back('{1, OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 18});
    vecs.push_back('{1, OP_REM,    32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 18});
    vecs.push_back('{1, OP_MUL,    32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         18});
    vecs.push_back('{1, OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 18});
    vecs.push_back('{0, OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{0, OP_REM,    32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{0, OP_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, 1});
    vecs.push_back('{0, OP_REMU,   32'd5,          32'd0,         32'd5,         1});
    vecs.push_back('{0, OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
    vecs.push_back('{0, OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});
    vecs.push_back('{2, OP_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, 34});
    vecs.push_back('{2, OP_REM,    32'd5,          32'd0,         32'd5,         34});
    vecs.push_back('{2, OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 34});
    vecs.push_back('{2, OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         34});
    vecs.push_back('{2, OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF, 34});
    vecs.push_back('{2, OP_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9, 34});

    foreach (vecs[i])
      run_op(vecs[i].s, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      n   = (rop[2] && ((rb == 32'd0) || (((rop == OP_DIV) || (rop == OP_REM)) &&
             (ra == 32'h8000_0000) && (rb == 32'hFFFF_FFFF)))) ? 1 : 18;
      run_op(1, rop, ra, rb, ref_model(rop, ra, rb), n, $sformatf("rand%0d", i));
    end

    // Backpressure: result held in DONE, pending request not accepted
    sel = 0;
    sb_q.push_back(32'd14);
    @(negedge clk); in_valid_d = 1'b1; op_d = OP_DIVU; a_d = 32'd100; b_d = 32'd7;
    @(negedge clk); op_d = OP_REMU; #1;
    n = 1;
    while (!out_valid_o && n < 200) begin @(negedge clk); #1; n++; end
    check("bp.latency", n, 34);
    held = result_o;
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (!out_valid_o || in_ready_o || result_o !== held) stable_ok = 1'b0;
    end
    check("bp.stable", stable_ok, 1);
    check("bp.result", held, sb_q.pop_front());
    out_ready_d = 1'b1; #1;
    check("bp.no_accept_in_done", in_ready_o, 0);
    @(negedge clk); out_ready_d = 1'b0; #1;
    check("bp.idle_ready", in_ready_o, 1);
    check("bp.idle_busy", busy_o, 0);
    sb_q.push_back(32'd2);
    @(negedge clk); in_valid_d = 1'b0; #1;
    n = 1;
    while (!out_valid_o && n < 200) begin @(negedge clk); #1; n++; end
    check("bp.next_latency", n, 34);
    check("bp.next_result", result_o, sb_q.pop_front());
    out_ready_d = 1'b1;
    @(negedge clk); out_ready_d = 1'b0;

    // Kill at CALC cycle 5: back to IDLE, never any out_valid
    @(negedge clk); in_valid_d = 1'b1; op_d = OP_MUL; a_d = 32'd3; b_d = 32'd5;
    @(negedge clk); in_valid_d = 1'b0;
    repeat (4) @(negedge clk);
    kill_d = 1'b1;
    @(negedge clk); kill_d = 1'b0; #1;
    check("kill.busy", busy_o, 0);
    check("kill.out_valid", out_valid_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); #1; if (out_valid_o) seen = 1'b1; end
    check("kill.never_valid", seen, 0);

    // Kill together with in_valid in IDLE: no accept
    @(negedge clk); in_valid_d = 1'b1; kill_d = 1'b1; op_d = OP_DIVU; a_d = 32'd9; b_d = 32'd3; #1;
    check("kill_idle.in_ready", in_ready_o, 0);
    @(negedge clk); in_valid_d = 1'b0; kill_d = 1'b0; #1;
    check("kill_idle.busy", busy_o, 0);

    // Reset mid-CALC
    run_op(0, OP_DIVU, 32'd100, 32'd7, 32'd14, 34, "pre_rst");
    @(negedge clk); in_valid_d = 1'b1; op_d = OP_MUL; a_d = 32'd11; b_d = 32'd13;
    @(negedge clk); in_valid_d = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst.held_result", result_o, 32'd14);
    rst = 1'b1;
    @(negedge clk); #1;
    check("rst.in_ready", in_ready_o, 1);
    check("rst.out_valid", out_valid_o, 0);
    check("rst.busy", busy_o, 0);
    check("rst.result", result_o, 0);
    rst = 1'b0;
    run_op(0, OP_MUL, 32'd11, 32'd13, 32'd143, 34, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
